equalize_lut: RTL and testbench

- Stage 2 of the histogram-equalization pipeline. Sits between the histogram stage and the output/remap stage.
- Reads the 256-bin pixel histogram from scratch SRAM and forms the running cumulative distribution.
- Scales each CDF value to an 8-bit equalized level.
- Packs 16 levels per 128-bit word and writes the 256-entry lookup table back to scratch SRAM, where the output stage reads it.

---
 rtl/equalize_lut.sv | 143 ++++++++++++++
 tb/tb_equalize_lut.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/equalize_lut.sv
// rtl/equalize_lut.sv - histogram-to-LUT equalization stage
// Reads 64 histogram words, accumulates the CDF, scales to 8-bit levels, writes 16 packed LUT words.
module equalize_lut #(
  parameter logic [14:0] CountBaseAddress     = 15'h000,
  parameter logic [14:0] EqualizedBaseAddress = 15'h000,
  parameter logic [6:0]  NumCountWords        = 7'd64,
  parameter logic [15:0] ScaleMul             = 16'd13926,
  parameter logic [4:0]  ScaleShift           = 5'd24
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [1:0]   Control,
  input  logic [127:0] ReadBusScratch,
  output logic [15:0]  ReadAddressScratch,
  output logic [15:0]  WriteAddressScratch,
  output logic [127:0] WriteBusScratch,
  output logic         WriteEnableScratch,
  output logic         flag
);

  typedef enum logic [1:0] {Idle = 2'd0, Read = 2'd1, Drain = 2'd2, Done = 2'd3} stateType;

  typedef struct packed {
    stateType        state;
    logic [15:0]     readAddress;
    logic [6:0]      readCount;
    logic            addrValid;
    logic [5:0]      addrWord;
    logic            dataValid;
    logic [5:0]      dataWord;
    logic [31:0]     acc;
    logic [3:0][31:0] cdf;
    logic            cdfValid;
    logic [5:0]      cdfWord;
    logic [127:0]    packBuffer;
    logic            packPending;
    logic [3:0]      packGroup;
    logic            writeEnable;
    logic            writeLast;
    logic [15:0]     writeAddress;
    logic [127:0]    writeBus;
    logic            flag;
  } regsType;

  regsType r;

  logic [15:0]      readBase;
  logic [15:0]      writeBase;
  logic [31:0]      running;
  logic [3:0][31:0] cdfNext;
  logic [127:0]     packNext;

  assign readBase  = {Control[1], CountBaseAddress};
  assign writeBase = {Control[1], EqualizedBaseAddress};

  function automatic logic [7:0] scaleLevel(input logic [31:0] cdf);
    logic [47:0] product;
    logic [47:0] shifted;
    product = 48'(cdf) * 48'(ScaleMul) + (48'd1 << (ScaleShift - 5'd1));
    shifted = product >> ScaleShift;
    scaleLevel = (shifted > 48'd255) ? 8'hFF : shifted[7:0];
  endfunction

  // Chained add: each bin's CDF includes every earlier bin of the same word.
  always_comb begin
    running = r.acc;
    for (int i = 0; i < 4; i++) begin
      running    = running + ReadBusScratch[32*i +: 32];
      cdfNext[i] = running;
    end
  end

  always_comb begin
    packNext = r.packBuffer;
    for (int i = 0; i < 4; i++)
      packNext[{r.cdfWord[1:0], 2'(i), 3'b000} +: 8] = scaleLevel(r.cdf[i]);
  end

  // Dropping the run enable behaves like a synchronous reset so an aborted run leaves nothing behind.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r <= '0;
    end else if (!Control[0]) begin
      r <= '0;
    end else begin
      r.addrValid <= 1'b0;
      unique case (r.state)
        Idle: begin
          r.readAddress <= readBase;
          r.readCount   <= 7'd1;
          r.addrValid   <= 1'b1;
          r.addrWord    <= 6'd0;
          r.state       <= Read;
        end
        Read: begin
          r.readAddress <= readBase + 16'(r.readCount);
          r.readCount   <= r.readCount + 7'd1;
          r.addrValid   <= 1'b1;
          r.addrWord    <= r.readCount[5:0];
          if (r.readCount == NumCountWords - 7'd1)
            r.state <= Drain;
        end
        Drain: begin
          if (r.writeEnable && r.writeLast) begin
            r.state <= Done;
            r.flag  <= 1'b1;
          end
        end
        Done: r.flag <= 1'b1;
        default: r.state <= Idle;
      endcase

      r.dataValid <= r.addrValid;
      r.dataWord  <= r.addrWord;

      r.cdfValid <= r.dataValid;
      r.cdfWord  <= r.dataWord;
      if (r.dataValid) begin
        r.cdf <= cdfNext;
        r.acc <= cdfNext[3];
      end

      r.packPending <= r.cdfValid && (r.cdfWord[1:0] == 2'd3);
      r.packGroup   <= r.cdfWord[5:2];
      if (r.cdfValid)
        r.packBuffer <= packNext;

      r.writeEnable <= r.packPending;
      r.writeLast   <= r.packPending && (r.packGroup == 4'd15);
      if (r.packPending) begin
        r.writeAddress <= writeBase + 16'(r.packGroup);
        r.writeBus     <= r.packBuffer;
      end
    end
  end

  assign ReadAddressScratch  = r.readAddress;
  assign WriteAddressScratch = r.writeAddress;
  assign WriteBusScratch     = r.writeBus;
  assign WriteEnableScratch  = r.writeEnable;
  assign flag                = r.flag;

endmodule

// File: tb/tb_equalize_lut.sv
// tb/tb_equalize_lut.sv - scoreboard bench for equalize_lut
module tb_equalize_lut;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   Control = 2'b00;
  logic [127:0] ReadBusScratch;
  logic [15:0]  ReadAddressScratch;
  logic [15:0]  WriteAddressScratch;
  logic [127:0] WriteBusScratch;
  logic         WriteEnableScratch;
  logic         flag;

  equalize_lut dut (
    .clock(clock),
    .reset(reset),
    .Control(Control),
    .ReadBusScratch(ReadBusScratch),
    .ReadAddressScratch(ReadAddressScratch),
    .WriteAddressScratch(WriteAddressScratch),
    .WriteBusScratch(WriteBusScratch),
    .WriteEnableScratch(WriteEnableScratch),
    .flag(flag)
  );

  always #5 clock = ~clock;

  logic [127:0] mem [0:63];
  logic [15:0]  ramAddr = 16'h0;
  always @(posedge clock) ramAddr <= ReadAddressScratch;
  assign ReadBusScratch = mem[ramAddr[5:0]];

  int cycle = 0;
  always @(posedge clock) cycle = cycle + 1;

  typedef struct {
    logic [15:0]  addr;
    logic [127:0] data;
    int           atEdge;
  } writeEntry;

  writeEntry     expectQ[$];
  writeEntry     head;
  logic [127:0]  lutSeen [0:15];
  int unsigned   hist [0:255];
  int            checkCount = 0;
  int            passCount = 0;
  logic          readActive = 1'b0;
  int            readStart = 0;
  logic [15:0]   readBaseAddr = 16'h0;
  int            runBase = 0;

  task automatic checkValue(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic loadHistogram();
    for (int j = 0; j < 64; j++)
      for (int i = 0; i < 4; i++)
        mem[j][32*i +: 32] = hist[4*j+i];
  endtask

  task automatic pushExpected(input logic bank, input int base, input int groups);
    longint       cdf;
    longint       lvl;
    logic [127:0] words [0:15];
    writeEntry    e;
    cdf = 0;
    for (int v = 0; v < 256; v++) begin
      cdf = cdf + longint'(hist[v]);
      lvl = (cdf * 13926 + (64'd1 << 23)) >> 24;
      if (lvl > 255) lvl = 255;
      words[v/16][8*(v%16) +: 8] = 8'(lvl);
    end
    for (int k = 0; k < groups; k++) begin
      e.addr   = {bank, 15'h0} + 16'(k);
      e.data   = words[k];
      e.atEdge = base + 8 + 4*k;
      expectQ.push_back(e);
    end
  endtask

  task automatic startRun(input logic bank, input int groups);
    Control      = {bank, 1'b1};
    runBase      = cycle;
    readStart    = cycle;
    readBaseAddr = {bank, 15'h0};
    readActive   = 1'b1;
    pushExpected(bank, runBase, groups);
  endtask

  task automatic waitFlag(input int expectedEdge, input string tag);
    int budget = 0;
    while (!flag && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    checkValue({tag, " flag raised"}, 128'(flag), 128'(1));
    checkValue({tag, " flag edge"}, 128'(cycle), 128'(expectedEdge));
  endtask

  task automatic finishRun(input string tag);
    checkValue({tag, " pending writes"}, 128'(expectQ.size()), 128'(0));
    repeat (3) @(negedge clock);
    checkValue({tag, " flag held"}, 128'(flag), 128'(1));
    Control    = 2'b00;
    readActive = 1'b0;
    @(negedge clock);
    checkValue({tag, " cleared outputs"},
               {WriteBusScratch[93:0], ReadAddressScratch, WriteAddressScratch, WriteEnableScratch, flag},
               128'(0));
  endtask

  always @(negedge clock) begin
    if (WriteEnableScratch) begin
      checkValue("write expected", 128'(expectQ.size() > 0), 128'(1));
      if (expectQ.size() > 0) begin
        head = expectQ.pop_front();
        checkValue("write address", 128'(WriteAddressScratch), 128'(head.addr));
        checkValue("write data", WriteBusScratch, head.data);
        checkValue("write edge", 128'(cycle), 128'(head.atEdge));
        lutSeen[WriteAddressScratch[3:0]] = WriteBusScratch;
      end
    end
    if (readActive && (cycle - readStart) >= 1 && (cycle - readStart) <= 64)
      checkValue("read address", 128'(ReadAddressScratch), 128'(readBaseAddr + 16'(cycle - readStart - 1)));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 reset = 1'b1;
    #1;
    checkValue("reset outputs", {ReadAddressScratch, WriteAddressScratch, WriteEnableScratch, flag}, 128'(0));
    checkValue("reset bus", WriteBusScratch, 128'(0));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Uniform histogram
    for (int v = 0; v < 256; v++) hist[v] = 1200;
    loadHistogram();
    startRun(1'b0, 16);
    waitFlag(runBase + 69, "uniform");
    finishRun("uniform");
    checkValue("uniform bin0", 128'(lutSeen[0][7:0]), 128'(1));
    checkValue("uniform bin127", 128'(lutSeen[7][127:120]), 128'(127));
    checkValue("uniform bin255", 128'(lutSeen[15][127:120]), 128'(255));

    // Every pixel in bin 0
    for (int v = 0; v < 256; v++) hist[v] = 0;
    hist[0] = 307200;
    loadHistogram();
    startRun(1'b0, 16);
    waitFlag(runBase + 69, "bin0");
    finishRun("bin0");
    checkValue("bin0 word0", lutSeen[0], {16{8'hFF}});
    checkValue("bin0 word15", lutSeen[15], {16{8'hFF}});

    // Every pixel in bin 255, upper bank
    for (int v = 0; v < 256; v++) hist[v] = 0;
    hist[255] = 307200;
    loadHistogram();
    startRun(1'b1, 16);
    waitFlag(runBase + 69, "bin255");
    finishRun("bin255");
    checkValue("bin255 word0", lutSeen[0], 128'(0));
    checkValue("bin255 word15", lutSeen[15], {8'hFF, 120'h0});

    // Abort at edge 30, restart at edge 35
    for (int v = 0; v < 256; v++) hist[v] = $urandom_range(0, 1200);
    loadHistogram();
    startRun(1'b0, 6);
    while (cycle < runBase + 29) @(negedge clock);
    Control    = 2'b00;
    readActive = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkValue("abort outputs zero",
                 {WriteBusScratch[93:0], ReadAddressScratch, WriteAddressScratch, WriteEnableScratch, flag},
                 128'(0));
    end
    checkValue("abort writes before drop", 128'(expectQ.size()), 128'(0));
    begin
      int firstBase;
      firstBase = runBase;
      startRun(1'b0, 16);
      waitFlag(firstBase + 34 + 69, "restart");
    end
    finishRun("restart");

    // Asynchronous reset during DRAIN
    for (int v = 0; v < 256; v++) hist[v] = 1200;
    loadHistogram();
    startRun(1'b0, 16);
    while (cycle < runBase + 66) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkValue("async reset outputs", {ReadAddressScratch, WriteAddressScratch, WriteEnableScratch, flag}, 128'(0));
    checkValue("async reset bus", WriteBusScratch, 128'(0));
    checkValue("writes before reset", 128'(expectQ.size()), 128'(1));
    expectQ.delete();
    readActive = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    startRun(1'b0, 16);
    waitFlag(runBase + 69, "post reset");
    finishRun("post reset");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
